cv32e40p_apu_arbiter: RTL and testbench



---
 rtl/cv32e40p_apu_core_pkg.sv | 14 +
 rtl/cv32e40p_apu_id_fifo.sv | 64 ++++++
 rtl/cv32e40p_apu_arbiter.sv | 150 +++++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU interface widths for CV32E40P, plus the port-id type used by the
// cluster FPU arbiter.
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  // Sized for the largest legal cluster (8 cores) so the type is parameter-free.
  localparam int APU_ARB_MAX_PORTS = 8;
  typedef logic [$clog2(APU_ARB_MAX_PORTS)-1:0] apu_port_id_t;

endpackage

// File: rtl/cv32e40p_apu_id_fifo.sv
// In-order FIFO of core port ids for FPU operations in flight.
// Synchronous active-high reset; pushes when full and pops when empty are dropped.
module cv32e40p_apu_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (int'(wr_ptr_q) == DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (int'(rd_ptr_q) == DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one FPU between NUM_PORTS cores: arbitrates requests, tracks issuers in
// order and routes responses back. CV32E40P_APU_ARB_ROUND_ROBIN_EN selects round-robin.
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ID_DEPTH  = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             core_apu_req_i      [NUM_PORTS],
  output logic                             core_apu_gnt_o      [NUM_PORTS],
  input  logic [APU_NARGS_CPU-1:0][31:0]   core_apu_operands_i [NUM_PORTS],
  input  logic [APU_WOP_CPU-1:0]           core_apu_op_i       [NUM_PORTS],
  input  logic [APU_NDSFLAGS_CPU-1:0]      core_apu_flags_i    [NUM_PORTS],
  output logic                             core_apu_rvalid_o   [NUM_PORTS],
  output logic [31:0]                      core_apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]      core_apu_rflags_o,
  output logic                             fpu_apu_req_o,
  input  logic                             fpu_apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]   fpu_apu_operands_o,
  output logic [APU_WOP_CPU-1:0]           fpu_apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]      fpu_apu_flags_o,
  input  logic                             fpu_apu_rvalid_i,
  input  logic [31:0]                      fpu_apu_rdata_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]      fpu_apu_rflags_i,
  output logic                             busy_o
);

  logic [NUM_PORTS-1:0] req_vec;
  logic                 any_req, accept, pop, lock_req;
  logic                 fifo_full, fifo_empty;
  logic                 lock_q, lock_d;
  apu_port_id_t         sel, arb_sel, fifo_head, lock_sel_q, lock_sel_d;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) req_vec[i] = core_apu_req_i[i];
  end
  assign any_req = |req_vec;

`ifdef CV32E40P_APU_ARB_ROUND_ROBIN_EN
  apu_port_id_t rr_ptr_q, rr_ptr_d;
  logic         found;

  // Two passes: first from rr_ptr upwards, then wrap around from port 0.
  always_comb begin
    arb_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && i >= int'(rr_ptr_q) && req_vec[i]) begin
        arb_sel = apu_port_id_t'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req_vec[i]) begin
        arb_sel = apu_port_id_t'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (int'(sel) == NUM_PORTS - 1) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    arb_sel = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_vec[i]) arb_sel = apu_port_id_t'(i);
    end
  end
`endif

  // A pending ungranted request keeps its port so the FPU-side payload holds.
  always_comb begin
    lock_req = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (int'(lock_sel_q) == i) lock_req = req_vec[i];
    end
    sel = (lock_q && lock_req) ? lock_sel_q : arb_sel;
  end

  assign fpu_apu_req_o = any_req & ~fifo_full;
  assign accept        = fpu_apu_req_o & fpu_apu_gnt_i;
  assign pop           = fpu_apu_rvalid_i & ~fifo_empty;
  assign lock_d        = fpu_apu_req_o & ~fpu_apu_gnt_i;
  assign lock_sel_d    = sel;

  always_comb begin
    fpu_apu_operands_o = '0;
    fpu_apu_op_o       = '0;
    fpu_apu_flags_o    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      core_apu_gnt_o[i]    = accept && (int'(sel) == i);
      core_apu_rvalid_o[i] = pop && (int'(fifo_head) == i);
      if (any_req && int'(sel) == i) begin
        fpu_apu_operands_o = core_apu_operands_i[i];
        fpu_apu_op_o       = core_apu_op_i[i];
        fpu_apu_flags_o    = core_apu_flags_i[i];
      end
    end
  end

  assign core_apu_result_o = fpu_apu_rdata_i;
  assign core_apu_rflags_o = fpu_apu_rflags_i;
  assign busy_o            = ~fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  cv32e40p_apu_id_fifo #(
    .DEPTH (ID_DEPTH),
    .WIDTH ($bits(apu_port_id_t))
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(fpu_apu_rvalid_i && fifo_empty))
        else $warning("[APU_ARB] rvalid ignored: ID FIFO empty");
      assert (!(lock_q && !lock_req))
        else $warning("[APU_ARB] core dropped request before grant");
    end
  end
`endif

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for cv32e40p_apu_arbiter (3 ports, ID_DEPTH 4); expectations
// follow CV32E40P_APU_ARB_ROUND_ROBIN_EN when it is defined.
module tb_cv32e40p_apu_arbiter;
  import cv32e40p_apu_core_pkg::*;

  localparam int NP    = 3;
  localparam int DEPTH = 4;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           req      [NP];
  logic                           gnt      [NP];
  logic [APU_NARGS_CPU-1:0][31:0] operands [NP];
  logic [APU_WOP_CPU-1:0]         op       [NP];
  logic [APU_NDSFLAGS_CPU-1:0]    flags    [NP];
  logic                           rvalid   [NP];
  logic [31:0]                    result;
  logic [APU_NUSFLAGS_CPU-1:0]    rflags;
  logic                           fpu_req, fpu_gnt, fpu_rvalid, busy;
  logic [APU_NARGS_CPU-1:0][31:0] fpu_operands;
  logic [APU_WOP_CPU-1:0]         fpu_op;
  logic [APU_NDSFLAGS_CPU-1:0]    fpu_flags;
  logic [31:0]                    fpu_rdata;
  logic [APU_NUSFLAGS_CPU-1:0]    fpu_rflags;
  logic [NP-1:0]                  gnt_vec, rvalid_vec;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      gnt_vec[i]    = gnt[i];
      rvalid_vec[i] = rvalid[i];
    end
  end

  cv32e40p_apu_arbiter #(.NUM_PORTS(NP), .ID_DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .core_apu_req_i      (req),
    .core_apu_gnt_o      (gnt),
    .core_apu_operands_i (operands),
    .core_apu_op_i       (op),
    .core_apu_flags_i    (flags),
    .core_apu_rvalid_o   (rvalid),
    .core_apu_result_o   (result),
    .core_apu_rflags_o   (rflags),
    .fpu_apu_req_o       (fpu_req),
    .fpu_apu_gnt_i       (fpu_gnt),
    .fpu_apu_operands_o  (fpu_operands),
    .fpu_apu_op_o        (fpu_op),
    .fpu_apu_flags_o     (fpu_flags),
    .fpu_apu_rvalid_i    (fpu_rvalid),
    .fpu_apu_rdata_i     (fpu_rdata),
    .fpu_apu_rflags_i    (fpu_rflags),
    .busy_o              (busy)
  );

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [NP-1:0] mask);
    for (int i = 0; i < NP; i++) req[i] = mask[i];
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    set_req('0);
    fpu_gnt    = 1'b0;
    fpu_rvalid = 1'b0;
    fpu_rdata  = '0;
    fpu_rflags = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req('0);
    fpu_gnt = 1'b0;
    fpu_rvalid = 1'b0;
    step();
    #4;
    checks++; if (gnt_vec !== 3'b000) begin failures++; $display("[TB] FAIL reset_gnt: got %b want 000", gnt_vec); end
    checks++; if (fpu_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_fpu_req: got %b want 0", fpu_req); end
    checks++; if (rvalid_vec !== 3'b000) begin failures++; $display("[TB] FAIL reset_rvalid: got %b want 000", rvalid_vec); end
    step();
    rst = 1'b0;
    #4;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    step();
  endtask

  task automatic test_single_port();
    logic [NP-1:0] exp_g, exp_r;
    do_reset();
    fpu_gnt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req[0]     = (c < 3);
      fpu_rvalid = (c >= 2);
      fpu_rdata  = 32'hCAFE_0000 + c;
      fpu_rflags = 5'(c + 3);
      #4;
      exp_g = (c < 3) ? 3'b001 : 3'b000;
      exp_r = (c >= 2) ? 3'b001 : 3'b000;
      checks++; if (gnt_vec !== exp_g) begin failures++; $display("[TB] FAIL single_gnt c%0d: got %b want %b", c, gnt_vec, exp_g); end
      checks++; if (rvalid_vec !== exp_r) begin failures++; $display("[TB] FAIL single_rvalid c%0d: got %b want %b", c, rvalid_vec, exp_r); end
      if (c == 0) begin
        checks++; if (fpu_op !== op[0] || fpu_operands !== operands[0] || fpu_flags !== flags[0]) begin
          failures++; $display("[TB] FAIL single_payload: got op %h flags %h want op %h flags %h", fpu_op, fpu_flags, op[0], flags[0]);
        end
      end
      if (c >= 2) begin
        checks++; if (result !== 32'hCAFE_0000 + c || rflags !== 5'(c + 3)) begin
          failures++; $display("[TB] FAIL single_result c%0d: got %h/%h want %h/%h", c, result, rflags, 32'hCAFE_0000 + c, 5'(c + 3));
        end
      end
      step();
    end
    fpu_rvalid = 1'b0;
    fpu_gnt    = 1'b0;
    #4;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_end: got %b want 0", busy); end
    checks++; if (fpu_op !== '0 || fpu_operands !== '0) begin failures++; $display("[TB] FAIL idle_payload: got op %h want 0", fpu_op); end
    step();
  endtask

  // seq holds the expected winning port of each of 4 accepts, 2 bits each, LSB first.
  task automatic test_arbitration(input logic [NP-1:0] mask, input logic [7:0] seq, input string name);
    logic [1:0]    p;
    logic [NP-1:0] exp;
    do_reset();
    fpu_gnt = 1'b1;
    set_req(mask);
    for (int c = 0; c < 4; c++) begin
      #4;
      p   = seq[2*c +: 2];
      exp = NP'(1) << p;
      checks++; if (gnt_vec !== exp) begin failures++; $display("[TB] FAIL %s_gnt c%0d: got %b want %b", name, c, gnt_vec, exp); end
      checks++; if (fpu_op !== op[p]) begin failures++; $display("[TB] FAIL %s_op c%0d: got %h want %h", name, c, fpu_op, op[p]); end
      step();
    end
    #4;
    checks++; if (fpu_req !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL %s_full: got req %b busy %b want req 0 busy 1", name, fpu_req, busy); end
    set_req('0);
    step();
    for (int c = 0; c < 4; c++) begin
      fpu_rvalid = 1'b1;
      #4;
      p   = seq[2*c +: 2];
      exp = NP'(1) << p;
      checks++; if (rvalid_vec !== exp) begin failures++; $display("[TB] FAIL %s_route c%0d: got %b want %b", name, c, rvalid_vec, exp); end
      step();
    end
    fpu_rvalid = 1'b0;
    #4;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL %s_drain: got busy %b want 0", name, busy); end
    step();
  endtask

  task automatic test_lock();
    logic [NP-1:0] req_t [5];
    logic          gnt_t [5];
    logic [NP-1:0] exp_t [5];
    logic [1:0]    port_t [5];
    req_t  = '{3'b010, 3'b011, 3'b011, 3'b011, 3'b001};
    gnt_t  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_t  = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001};
    port_t = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_req(req_t[c]);
      fpu_gnt = gnt_t[c];
      #4;
      checks++; if (fpu_req !== 1'b1) begin failures++; $display("[TB] FAIL lock_req c%0d: got %b want 1", c, fpu_req); end
      checks++; if (fpu_op !== op[port_t[c]]) begin failures++; $display("[TB] FAIL lock_op c%0d: got %h want %h", c, fpu_op, op[port_t[c]]); end
      checks++; if (gnt_vec !== exp_t[c]) begin failures++; $display("[TB] FAIL lock_gnt c%0d: got %b want %b", c, gnt_vec, exp_t[c]); end
      step();
    end
    set_req('0);
    fpu_gnt    = 1'b0;
    fpu_rvalid = 1'b1;
    #4;
    checks++; if (rvalid_vec !== 3'b010) begin failures++; $display("[TB] FAIL lock_route0: got %b want 010", rvalid_vec); end
    step();
    #4;
    checks++; if (rvalid_vec !== 3'b001) begin failures++; $display("[TB] FAIL lock_route1: got %b want 001", rvalid_vec); end
    step();
    fpu_rvalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    set_req(3'b001);
    fpu_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #4;
      checks++; if (gnt_vec !== 3'b001) begin failures++; $display("[TB] FAIL full_fill c%0d: got %b want 001", c, gnt_vec); end
      step();
    end
    #4;
    checks++; if (fpu_req !== 1'b0 || gnt_vec !== 3'b000 || busy !== 1'b1) begin
      failures++; $display("[TB] FAIL full_block: got req %b gnt %b busy %b want 0 000 1", fpu_req, gnt_vec, busy);
    end
    step();
    fpu_rvalid = 1'b1;
    #4;
    checks++; if (fpu_req !== 1'b0 || gnt_vec !== 3'b000) begin failures++; $display("[TB] FAIL full_pop_same: got req %b gnt %b want 0 000", fpu_req, gnt_vec); end
    checks++; if (rvalid_vec !== 3'b001) begin failures++; $display("[TB] FAIL full_pop_rvalid: got %b want 001", rvalid_vec); end
    step();
    fpu_rvalid = 1'b0;
    #4;
    checks++; if (fpu_req !== 1'b1 || gnt_vec !== 3'b001) begin failures++; $display("[TB] FAIL full_reassert: got req %b gnt %b want 1 001", fpu_req, gnt_vec); end
    step();
    #4;
    checks++; if (fpu_req !== 1'b0) begin failures++; $display("[TB] FAIL full_again: got req %b want 0", fpu_req); end
    set_req('0);
    step();
    fpu_gnt    = 1'b0;
    fpu_rvalid = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      #4;
      checks++; if (rvalid_vec !== 3'b001) begin failures++; $display("[TB] FAIL full_drain c%0d: got %b want 001", c, rvalid_vec); end
      step();
    end
    fpu_rvalid = 1'b0;
    #4;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL full_empty: got busy %b want 0", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(3'b001);
    fpu_gnt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #4;
      checks++; if (gnt_vec !== 3'b001) begin failures++; $display("[TB] FAIL midrst_issue c%0d: got %b want 001", c, gnt_vec); end
      step();
    end
    set_req('0);
    #4;
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy_before: got %b want 1", busy); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #4;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy_after: got %b want 0", busy); end
    step();
    fpu_rvalid = 1'b1;
    #4;
    checks++; if (rvalid_vec !== 3'b000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_stray: got rvalid %b busy %b want 000 0", rvalid_vec, busy); end
    step();
    fpu_rvalid = 1'b0;
    set_req(3'b011);
    #4;
    checks++; if (gnt_vec !== 3'b001) begin failures++; $display("[TB] FAIL midrst_ptr: got %b want 001", gnt_vec); end
    step();
    set_req('0);
    fpu_gnt    = 1'b0;
    fpu_rvalid = 1'b1;
    #4;
    checks++; if (rvalid_vec !== 3'b001) begin failures++; $display("[TB] FAIL midrst_route: got %b want 001", rvalid_vec); end
    step();
    fpu_rvalid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      operands[i] = {32'h3000_0000 + i, 32'h2000_0000 + i, 32'h1000_0000 + i};
      op[i]       = APU_WOP_CPU'(8 + i);
      flags[i]    = APU_NDSFLAGS_CPU'(100 + i);
    end
    fpu_rdata  = '0;
    fpu_rflags = '0;
    test_reset();
    test_single_port();
`ifdef CV32E40P_APU_ARB_ROUND_ROBIN_EN
    test_arbitration(3'b011, {2'd1, 2'd0, 2'd1, 2'd0}, "rr_p0p1");
    test_arbitration(3'b101, {2'd2, 2'd0, 2'd2, 2'd0}, "rr_p0p2");
`else
    test_arbitration(3'b011, {2'd0, 2'd0, 2'd0, 2'd0}, "fixed_p0p1");
    test_arbitration(3'b101, {2'd0, 2'd0, 2'd0, 2'd0}, "fixed_p0p2");
`endif
    test_lock();
    test_fifo_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
